// File: rtl/nucleo_pkg.sv
// Shared constants and types for the nucleo single-cycle MIPS32 subset core.
package nucleo_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    reg_dst;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    branch_ne;
        logic    jump;
        alu_op_t alu_op;
    } ctrl_t;

    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/nucleo_alu.sv
// Combinational 32-bit ALU: add, sub, and, or, signed set-less-than, plus zero flag.
module nucleo_alu
    import nucleo_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] result_c,
    output logic              zero_c
);

    always_comb begin
        result_c = '0;
        case (op)
            ALU_ADD: result_c = a + b;
            ALU_SUB: result_c = a - b;
            ALU_AND: result_c = a & b;
            ALU_OR:  result_c = a | b;
            ALU_SLT: result_c = DATA_W'($signed(a) < $signed(b));
            default: result_c = '0;
        endcase
    end

    assign zero_c = (result_c == '0);

endmodule

// File: rtl/nucleo_top.sv
// Single-cycle MIPS32 subset core (ArqMIPS32 top): one instruction per clock.
// Define NUCLEO_BNE_EN to decode opcode 0x05 as bne; otherwise it executes as a NOP.
module nucleo_top
    import nucleo_pkg::*;
#(
    parameter int unsigned ADDRESS_INSTRUCCION = 32,
    parameter int unsigned IMEM_WORDS          = 256,
    parameter int unsigned DMEM_WORDS          = 256,
    parameter string       IMEM_INIT_FILE      = "program.hex"
) (
    input  logic                           clk,
    input  logic                           reset_pc,
    input  logic [ADDRESS_INSTRUCCION-1:0] pc_in,
    output logic [ADDRESS_INSTRUCCION-1:0] pc_out,
    output logic [DATA_W-1:0]              instr_out,
    output logic                           wb_en,
    output logic [REG_ADDR_W-1:0]          wb_addr,
    output logic [DATA_W-1:0]              wb_data
);

    localparam int unsigned AW      = ADDRESS_INSTRUCCION;
    localparam int unsigned IMEM_AW = $clog2(IMEM_WORDS);
    localparam int unsigned DMEM_AW = $clog2(DMEM_WORDS);
    localparam bit          HAS_INIT = (IMEM_INIT_FILE != "");

    logic [DATA_W-1:0] imem [IMEM_WORDS];
    logic [DATA_W-1:0] dmem [DMEM_WORDS];
    logic [DATA_W-1:0] regs [32];

    logic [AW-1:0]         pc_q, pc_plus4, br_target, j_target, pc_next;
    logic [DATA_W-1:0]     instr, imm_ext, rs_val, rt_val, alu_b, alu_result, load_data;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [DMEM_AW-1:0]    dmem_idx;
    logic                  imem_hit, dmem_hit, alu_zero, take_branch, mem_we;
    ctrl_t                 ctrl;
    logic                  unused_bits;

    // During reset the PC output follows pc_in directly.
    assign pc_out    = reset_pc ? pc_q : pc_in;
    assign imem_hit  = (pc_out[AW-1:IMEM_AW+2] == '0);
    assign instr     = imem_hit ? imem[pc_out[IMEM_AW+1:2]] : '0;
    assign instr_out = instr;

    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign imm_ext = sext16(instr[15:0]);
    assign rs_val  = (rs == '0) ? '0 : regs[rs];
    assign rt_val  = (rt == '0) ? '0 : regs[rt];

    // Control decoder: anything not listed leaves every control bit clear (NOP).
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        case (instr[31:26])
            OP_RTYPE: begin
                ctrl.reg_dst = 1'b1;
                case (instr[5:0])
                    FN_ADD:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
                    FN_SUB:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB; end
                    FN_AND:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND; end
                    FN_OR:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;  end
                    FN_SLT:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLT; end
                    default: ctrl.reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_LW: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_read  = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
`ifdef NUCLEO_BNE_EN
            OP_BNE: begin
                ctrl.branch    = 1'b1;
                ctrl.branch_ne = 1'b1;
                ctrl.alu_op    = ALU_SUB;
            end
`endif
            OP_J:    ctrl.jump = 1'b1;
            default: ctrl = '0;
        endcase
    end

    assign alu_b = ctrl.alu_src ? imm_ext : rt_val;

    nucleo_alu u_alu (
        .a        (rs_val),
        .b        (alu_b),
        .op       (ctrl.alu_op),
        .result_c (alu_result),
        .zero_c   (alu_zero)
    );

    assign dmem_hit  = (alu_result[DATA_W-1:DMEM_AW+2] == '0);
    assign dmem_idx  = alu_result[DMEM_AW+1:2];
    assign load_data = dmem_hit ? dmem[dmem_idx] : '0;
    assign mem_we    = reset_pc & ctrl.mem_write & dmem_hit;

    assign wb_addr = ctrl.reg_dst ? rd : rt;
    assign wb_data = ctrl.mem_read ? load_data : alu_result;
    assign wb_en   = reset_pc & ctrl.reg_write & (wb_addr != '0);

    assign pc_plus4    = pc_q + AW'(4);
    assign br_target   = pc_plus4 + AW'({imm_ext[29:0], 2'b00});
    assign j_target    = {pc_plus4[AW-1:28], instr[25:0], 2'b00};
    assign take_branch = ctrl.branch & (alu_zero ^ ctrl.branch_ne);
    assign pc_next     = ctrl.jump ? j_target : (take_branch ? br_target : pc_plus4);

    always_ff @(posedge clk or negedge reset_pc) begin
        if (!reset_pc) pc_q <= pc_in;
        else           pc_q <= pc_next;
    end

    always_ff @(posedge clk or negedge reset_pc) begin
        if (!reset_pc) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Data RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) dmem[dmem_idx] <= rt_val;
    end

    assign unused_bits = ^{instr[10:6], imm_ext[31:30], HAS_INIT};

endmodule

// File: tb/tb_nucleo_top.sv
// Scoreboard bench for nucleo_top: an instruction-level model predicts every cycle's outputs.
module tb_nucleo_top;

    logic        clk = 1'b0;
    logic        reset_pc;
    logic [31:0] pc_in;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    nucleo_top #(.IMEM_INIT_FILE("")) dut (
        .clk       (clk),
        .reset_pc  (reset_pc),
        .pc_in     (pc_in),
        .pc_out    (pc_out),
        .instr_out (instr_out),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] prog   [256];
    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [256];
    logic [31:0] m_pc;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int tgt);
        return {6'h02, 26'(tgt)};
    endfunction

    function automatic logic [31:0] m_fetch(input logic [31:0] pc);
        if (pc < 32'd1024) return prog[8'(pc / 32'd4)];
        return 32'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h at t=%0t", name, got, want, $time);
        end
    endtask

    task automatic m_reset();
        m_pc = pc_in;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    // Executes one instruction on the model and returns what the core must show meanwhile.
    task automatic model_cycle(output exp_t e);
        logic [31:0] ins, a, b, res, simm, addr, nxt;
        logic [4:0]  rs, rt, rd, dest;
        logic [5:0]  op, fn;
        logic        we;
        ins  = m_fetch(m_pc);
        op   = ins[31:26];
        fn   = ins[5:0];
        rs   = ins[25:21];
        rt   = ins[20:16];
        rd   = ins[15:11];
        a    = m_regs[rs];
        b    = m_regs[rt];
        simm = 32'(int'($signed(ins[15:0])));
        addr = a + simm;
        nxt  = m_pc + 32'd4;
        we   = 1'b0;
        dest = 5'd0;
        res  = 32'd0;
        case (op)
            6'h00: begin
                dest = rd;
                we   = 1'b1;
                case (fn)
                    6'h20:   res = a + b;
                    6'h22:   res = a - b;
                    6'h24:   res = a & b;
                    6'h25:   res = a | b;
                    6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: we = 1'b0;
                endcase
            end
            6'h08: begin dest = rt; we = 1'b1; res = a + simm; end
            6'h23: begin
                dest = rt;
                we   = 1'b1;
                res  = (addr < 32'd1024) ? m_dmem[8'(addr / 32'd4)] : 32'd0;
            end
            6'h2B: if (addr < 32'd1024) m_dmem[8'(addr / 32'd4)] = b;
            6'h04: if (a == b) nxt = m_pc + 32'd4 + simm * 32'd4;
`ifdef NUCLEO_BNE_EN
            6'h05: if (a != b) nxt = m_pc + 32'd4 + simm * 32'd4;
`endif
            6'h02: nxt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, ins[25:0]} << 2);
            default: ;
        endcase
        e.pc      = m_pc;
        e.instr   = ins;
        e.wb_en   = we && (dest != 5'd0);
        e.wb_addr = dest;
        e.wb_data = res;
        if (e.wb_en) m_regs[dest] = res;
        m_pc = nxt;
    endtask

    task automatic run(input int n);
        exp_t e;
        repeat (n) begin
            model_cycle(e);
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input int n);
        exp_t e;
        repeat (n) begin
            e.pc      = pc_in;
            e.instr   = m_fetch(pc_in);
            e.wb_en   = 1'b0;
            e.wb_addr = 5'd0;
            e.wb_data = 32'd0;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares whatever the core presents against the oldest prediction.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_out", pc_out, e.pc);
            chk("instr_out", instr_out, e.instr);
            chk("wb_en", 32'(wb_en), 32'(e.wb_en));
            if (e.wb_en) begin
                chk("wb_addr", 32'(wb_addr), 32'(e.wb_addr));
                chk("wb_data", wb_data, e.wb_data);
            end
        end
    end

    initial begin
        int k, ra, rb, rc;
        for (int i = 0; i < 256; i++) prog[i] = 32'd0;
        prog[0]  = enc_i('h08, 0, 1, 5);
        prog[1]  = enc_i('h08, 0, 2, -3);
        prog[2]  = enc_r(1, 2, 3, 'h20);
        prog[3]  = enc_r(2, 1, 4, 'h22);
        prog[4]  = enc_r(2, 1, 5, 'h2A);
        prog[5]  = enc_i('h2B, 0, 1, 8);
        prog[6]  = enc_i('h23, 0, 6, 8);
        prog[7]  = enc_i('h08, 0, 0, 7);
        prog[8]  = enc_i('h04, 1, 1, 2);
        prog[9]  = enc_i('h08, 0, 10, 'h77);
        prog[10] = enc_i('h08, 0, 10, 'h77);
        prog[11] = enc_i('h04, 1, 2, 3);
        prog[12] = enc_i('h05, 1, 2, 1);
        prog[13] = enc_i('h08, 0, 8, 99);
        prog[14] = enc_j('h40);
        prog[15] = enc_i('h23, 0, 7, 8);
        prog[16] = enc_r(7, 1, 9, 'h20);
        prog[17] = enc_j('h40);
        prog[64] = enc_i('h2B, 0, 2, 12);
        for (int i = 65; i < 104; i++) begin
            k  = int'($urandom_range(0, 9));
            ra = int'($urandom_range(0, 7));
            rb = int'($urandom_range(0, 7));
            rc = int'($urandom_range(0, 7));
            case (k)
                0: prog[i] = enc_i('h08, ra, rb, int'($urandom_range(0, 65535)));
                1, 2, 3, 4: begin
                    case ($urandom_range(0, 4))
                        0:       prog[i] = enc_r(ra, rb, rc, 'h20);
                        1:       prog[i] = enc_r(ra, rb, rc, 'h22);
                        2:       prog[i] = enc_r(ra, rb, rc, 'h24);
                        3:       prog[i] = enc_r(ra, rb, rc, 'h25);
                        default: prog[i] = enc_r(ra, rb, rc, 'h2A);
                    endcase
                end
                5: prog[i] = enc_r(ra, rb, rc, ($urandom_range(0, 1) == 0) ? 'h21 : 'h00);
                6: begin
                    case ($urandom_range(0, 2))
                        0:       prog[i] = enc_i('h2B, 0, rb, 12);
                        1:       prog[i] = enc_i('h2B, 0, rb, 'h7FF0);
                        default: prog[i] = enc_i('h2B, 0, rb, -8);
                    endcase
                end
                7: begin
                    case ($urandom_range(0, 2))
                        0:       prog[i] = enc_i('h23, 0, rb, 8);
                        1:       prog[i] = enc_i('h23, 0, rb, 12);
                        default: prog[i] = enc_i('h23, 0, rb, -16);
                    endcase
                end
                8: prog[i] = enc_i('h04, ra, rb, int'($urandom_range(1, 2)));
                default: begin
                    case ($urandom_range(0, 2))
                        0:       prog[i] = enc_i('h05, ra, rb, int'($urandom_range(1, 2)));
                        1:       prog[i] = enc_i('h0C, ra, rb, int'($urandom_range(0, 65535)));
                        default: prog[i] = enc_i('h3F, ra, rb, int'($urandom_range(0, 65535)));
                    endcase
                end
            endcase
        end
        prog[104] = enc_j('h40);
        prog[105] = enc_j('h40);
        prog[106] = enc_j('h40);
        for (int i = 0; i < 256; i++) dut.imem[i] = prog[i];

        // Power-up reset from address 0, then the directed program and random loop.
        reset_pc = 1'b1;
        pc_in    = 32'd0;
        #1 reset_pc = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        hold(2);
        reset_pc = 1'b1;
        run(220);

        // Asynchronous reset between edges lands on the lw/add check sequence.
        #2;
        pc_in    = 32'h0000_003C;
        reset_pc = 1'b0;
        #1 chk("async_reset_pc", pc_out, 32'h0000_003C);
        m_reset();
        hold(1);
        reset_pc = 1'b1;
        run(60);

        // pc_out tracks pc_in while held; release executes ROM word 4 first.
        reset_pc = 1'b0;
        pc_in    = 32'hFFFF_FFF8;
        m_reset();
        hold(2);
        pc_in = 32'h0000_0010;
        m_reset();
        hold(2);
        reset_pc = 1'b1;
        run(10);

        // Fetch past the end of the ROM reads zero.
        reset_pc = 1'b0;
        pc_in    = 32'h0000_03F8;
        m_reset();
        hold(1);
        reset_pc = 1'b1;
        run(5);

        // PC wrap-around from the top of the address space.
        reset_pc = 1'b0;
        pc_in    = 32'hFFFF_FFF8;
        m_reset();
        hold(1);
        reset_pc = 1'b1;
        run(5);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
